display_port_arbiter: RTL
=========================

// Module: display_port_arbiter
// PURPOSE
//  Shares the board display resources (32-bit hex-display word, 32-bit red-LED word) between two
//  requesters: req 0 = PCIe host PIO path, req 1 = local board logic (buttons/inport driven).
//  Round-robin request/grant arbiter with a bounded tenure. Output registers feed the
//  hex_display / led_r external connections. Only the granted requester can update them.
// PARAMETERS
//  MAX_HOLD    256           cycles a grant may last while the other requester waits (>=2)
//  HEX_RESET   32'hFFFF_FFFF hex_out reset value (segments active-low, all off)
//  LED_RESET   32'h0000_0000 led_out reset value
// PORTS
//  clk_clk        in   1   system clock
//  reset_reset_n  in   1   asynchronous, active-low reset
//  req_i          in   2   request, bit n = requester n; level, held until done
//  wr_i           in   2   write strobe, bit n; honoured only while gnt_o[n]=1
//  hex0_i/hex1_i  in   32  hex word from requester 0/1
//  led0_i/led1_i  in   32  LED word from requester 0/1
//  gnt_o          out  2   one-hot or zero grant
//  preempt_o      out  1   1-cycle pulse when a grant is revoked by the MAX_HOLD timer
//  hex_out        out  32  registered hex-display word
//  led_out        out  32  registered red-LED word
//  busy_o         out  1   gnt_o != 0
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, gnt_o=0, preempt_o=0, busy_o=0,
//   hex_out=HEX_RESET, led_out=LED_RESET, hold counter=0, last-served pointer=1 (req 0 wins first).
//  FSM states: IDLE, GNT0, GNT1.
//   IDLE: req_i==00 stays. One bit set -> grant it. Both set -> grant the one that is not
//    last-served. gnt_o asserts the cycle after req_i is sampled (1-cycle latency).
//   GNTn: hold counter increments each cycle; it is cleared on entry.
//    req_i[n] drops -> next cycle gnt_o=0 and state IDLE. last-served=n. No back-to-back
//     grant in the same cycle: at least one IDLE cycle between tenures.
//    Counter reaches MAX_HOLD-1 with req_i[other]=1 -> revoke: preempt_o pulses,
//     gnt_o=0, state IDLE, last-served=n. The other requester wins in IDLE.
//    Counter saturates at MAX_HOLD-1 if the other requester is not waiting. No revoke then.
//  Write: in a cycle with gnt_o[n]=1 and wr_i[n]=1, hex_out<=hexn_i and led_out<=ledn_i.
//   The new value is visible the next cycle. wr_i from a non-granted requester is ignored.
//   A write in the same cycle as a revoke or release is still honoured, because gnt_o
//   is still high in that cycle.
//  Outputs hold their last value between tenures and never return to the reset value
//   except on reset.
//  Reset mid-tenure: grant dropped immediately, outputs forced to reset values.
//  req_i==11 during GNTn with req_i[n] dropping: one IDLE cycle, then grant the other.
// TESTING
//  1 reset, req_i=00 -> gnt_o=00, hex_out=FFFFFFFF, led_out=0, busy_o=0.
//  2 req_i=01, wr_i=01, hex0_i=12345678 -> gnt_o=01 next cycle; hex_out=12345678 one cycle after wr.
//  3 req_i=11 from IDLE after reset -> gnt 01. Drop req0 -> one IDLE cycle, then gnt 10.
//    Re-raise req0 with req1 -> next grant goes to 01.
//  4 hold req_i=11 with req0 granted, MAX_HOLD=8 -> preempt_o pulse at cycle 8 of tenure;
//    gnt 10 two cycles later.
//  5 gnt_o=01 and wr_i=10 with hex1_i=DEADBEEF -> hex_out unchanged.
//  6 assert reset_reset_n=0 mid-GNT1 after writes -> gnt_o=0 and hex_out=FFFFFFFF
//    asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/display_port_arbiter.sv
// Two-requester round-robin arbiter for the board hex-display and red-LED words.
// Ports: clk_clk/reset_reset_n, req_i/wr_i per requester, hex0/1_i, led0/1_i
//        in; gnt_o, preempt_o, busy_o, registered hex_out/led_out out.
module display_port_arbiter #(
    parameter int unsigned MAX_HOLD  = 256,
    parameter logic [31:0] HEX_RESET = 32'hFFFF_FFFF,
    parameter logic [31:0] LED_RESET = 32'h0000_0000
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [1:0]  req_i,
    input  logic [1:0]  wr_i,
    input  logic [31:0] hex0_i,
    input  logic [31:0] hex1_i,
    input  logic [31:0] led0_i,
    input  logic [31:0] led1_i,
    output logic [1:0]  gnt_o,
    output logic        preempt_o,
    output logic [31:0] hex_out,
    output logic [31:0] led_out,
    output logic        busy_o
);

    localparam int unsigned CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic [31:0]   hex_q, hex_d;
    logic [31:0]   led_q, led_d;

    logic own_req;
    logic oth_req;
    logic hold_done;
    logic revoke;
    logic release_w;
    logic wr0;
    logic wr1;

    // State register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            hex_q   <= HEX_RESET;
            led_q   <= LED_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            hex_q   <= hex_d;
            led_q   <= led_d;
        end
    end

    // Current owner's request and the competitor's request
    always_comb begin
        own_req = 1'b0;
        oth_req = 1'b0;
        unique case (state_q)
            GNT0: begin
                own_req = req_i[0];
                oth_req = req_i[1];
            end
            GNT1: begin
                own_req = req_i[1];
                oth_req = req_i[0];
            end
            default: begin
                own_req = 1'b0;
                oth_req = 1'b0;
            end
        endcase
    end

    assign hold_done = (cnt_q == HOLD_MAX);

    // A voluntary release takes priority over a revoke in the same cycle
    assign release_w = (state_q != IDLE) && !own_req;
    assign revoke    = own_req && oth_req && hold_done;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE: begin
                // Contention goes to whoever was not served last
                if (req_i[0] && (!req_i[1] || last_q)) begin
                    state_d = GNT0;
                end else if (req_i[1]) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (release_w || revoke) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end else begin
                    cnt_d = hold_done ? cnt_q : cnt_q + 1'b1;
                end
            end
            GNT1: begin
                if (release_w || revoke) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end else begin
                    cnt_d = hold_done ? cnt_q : cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        gnt_o     = 2'b00;
        preempt_o = 1'b0;
        unique case (state_q)
            GNT0: gnt_o = 2'b01;
            GNT1: gnt_o = 2'b10;
            default: gnt_o = 2'b00;
        endcase
        preempt_o = revoke && !release_w;
        busy_o    = (gnt_o != 2'b00);
    end

    // Display write path: only the granted requester's strobe counts,
    // including in its final (release/revoke) cycle.
    assign wr0 = gnt_o[0] & wr_i[0];
    assign wr1 = gnt_o[1] & wr_i[1];

    always_comb begin
        hex_d = hex_q;
        led_d = led_q;
        unique case (1'b1)
            wr0: begin
                hex_d = hex0_i;
                led_d = led0_i;
            end
            wr1: begin
                hex_d = hex1_i;
                led_d = led1_i;
            end
            default: begin
                hex_d = hex_q;
                led_d = led_q;
            end
        endcase
    end

    assign hex_out = hex_q;
    assign led_out = led_q;

endmodule
